// File: rtl/wait_rr_arbiter.sv
// Round-robin arbiter for one shared signed operand register; each grant is
// followed by a fixed count-down hold during which no new grant is issued.
module wait_rr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_W-1:0]       req_data,
  input  logic                            hold_abort,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            out_valid,
  output logic signed [DATA_W-1:0]        out_data,
  output logic                            busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic [NUM_REQ-1:0]         gnt_q, gnt_d;
  logic [ID_W-1:0]            grant_id_q, grant_id_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]   out_data_q, out_data_d;

  logic signed [DATA_W-1:0]   data_arr [NUM_REQ];
  logic                       win_found;
  logic [ID_W-1:0]            win_id;
  logic [ID_W-1:0]            cand;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Search starts just after the last winner and wraps; first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((32'(ptr_q) + off) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    grant_id_d  = grant_id_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (win_found && !hold_abort) begin
          gnt_d[win_id] = 1'b1;
          grant_id_d    = win_id;
          out_valid_d   = 1'b1;
          out_data_d    = data_arr[win_id];
          cnt_d         = 8'(HOLD_CYCLES);
          ptr_d         = win_id;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        // Abort and the final decrement both land the counter at zero.
        if (hold_abort || cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      grant_id_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      grant_id_q  <= grant_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign grant_id  = grant_id_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == HOLD);

endmodule
